// File: rtl/rstmgr_pkg.sv
// Shared types and constants for the reset manager sequencer.
package rstmgr_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        IDLE    = 2'd3
    } rst_state_e;

    localparam int unsigned POR_CAUSE_BIT = 0;

endpackage

// File: rtl/rst_req_sync.sv
// Multi-flop synchroniser for one reset request; clears to 0 on rst_i.
module rst_req_sync #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d,
    output logic q
);

    logic [SyncStages-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], d};
        end
    end

    assign q = sync_q[SyncStages-1];

endmodule

// File: rtl/rstmgr_seq.sv
// Reset manager: synchronises requests, stretches the reset, releases domains
// in index order with a fixed gap, and keeps a sticky record of the cause.
module rstmgr_seq
    import rstmgr_pkg::*;
#(
    parameter int unsigned NumSrc        = 4,
    parameter int unsigned NumDomains    = 3,
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned StretchCycles = 16,
    parameter int unsigned ReleaseGap    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumSrc-1:0]     rst_req_i,
    input  logic [NumSrc-1:0]     rst_req_en_i,
    input  logic                  rst_cause_clr_i,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic [NumSrc:0]       rst_cause_o,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = $clog2(StretchCycles + 1);
    localparam int unsigned GAP_W = $clog2(ReleaseGap + 1);
    localparam int unsigned IDX_W = $clog2(NumDomains + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(StretchCycles - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(ReleaseGap - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NumDomains - 1);
    localparam logic [NumSrc:0]  POR_CAUSE = (NumSrc + 1)'(1) << POR_CAUSE_BIT;

    logic [NumSrc-1:0]     req_sync;
    logic [NumSrc-1:0]     req_en_s;
    logic                  req_s;

    rst_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [GAP_W-1:0]      gap_q;
    logic [IDX_W-1:0]      idx_q;
    logic [NumDomains-1:0] dom_q;
    logic [NumSrc:0]       cause_q;

    for (genvar g = 0; g < NumSrc; g++) begin : g_sync
        rst_req_sync #(
            .SyncStages(SyncStages)
        ) u_sync (
            .clk_i(clk_i),
            .rst_i(rst_i),
            .d    (rst_req_i[g]),
            .q    (req_sync[g])
        );
    end

    // Disabled sources are masked after the synchroniser, so enable changes
    // never reach the FSM through a metastable path.
    assign req_en_s = req_sync & rst_req_en_i;
    assign req_s    = |req_en_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= STRETCH;
            cnt_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        state_q <= ASSERT;
                        dom_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                ASSERT: begin
                    dom_q <= '0;
                    cnt_q <= '0;
                    if (!req_s) begin
                        state_q <= STRETCH;
                    end
                end
                STRETCH: begin
                    if (req_s) begin
                        state_q <= ASSERT;
                        dom_q   <= '0;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        dom_q   <= NumDomains'(1);
                        idx_q   <= IDX_W'(1);
                        gap_q   <= '0;
                        state_q <= (NumDomains == 1) ? IDLE : RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (req_s) begin
                        // Abandon the partial release; every domain goes back down.
                        state_q <= ASSERT;
                        dom_q   <= '0;
                        cnt_q   <= '0;
                        gap_q   <= '0;
                    end else if (gap_q == GAP_LAST) begin
                        for (int i = 0; i < NumDomains; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                dom_q[i] <= 1'b1;
                            end
                        end
                        idx_q <= idx_q + IDX_W'(1);
                        gap_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= ASSERT;
                    dom_q   <= '0;
                end
            endcase
        end
    end

    // Set has priority over clear so a request landing with the clear is kept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cause_q <= POR_CAUSE;
        end else begin
            cause_q <= (rst_cause_clr_i ? '0 : cause_q) | {req_en_s, 1'b0};
        end
    end

    assign domain_rst_no = dom_q;
    assign rst_cause_o   = cause_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_rstmgr_seq.sv
// Directed bench for rstmgr_seq with default parameters (4 sources, 3 domains).
module tb_rstmgr_seq;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] rst_req_i = '0;
    logic [3:0] rst_req_en_i = 4'hF;
    logic       rst_cause_clr_i = 1'b0;
    logic [2:0] domain_rst_no;
    logic [4:0] rst_cause_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    rstmgr_seq dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rst_req_i      (rst_req_i),
        .rst_req_en_i   (rst_req_en_i),
        .rst_cause_clr_i(rst_cause_clr_i),
        .domain_rst_no  (domain_rst_no),
        .rst_cause_o    (rst_cause_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] exp_dom;
        logic       exp_busy;
        rst_i = 1'b1;
        rst_req_i = '0;
        rst_req_en_i = 4'hF;
        rst_cause_clr_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (domain_rst_no !== 3'b000) begin
            errors++;
            $display("FAIL reset_dom got %b exp 000", domain_rst_no);
        end
        checks++;
        if (rst_cause_o !== 5'b00001) begin
            errors++;
            $display("FAIL reset_cause got %b exp 00001", rst_cause_o);
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy got %b exp 1", busy_o);
        end
        rst_i = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            tick();
            exp_dom = (e >= 24) ? 3'b111 : (e >= 20) ? 3'b011 : (e >= 16) ? 3'b001 : 3'b000;
            exp_busy = (e < 24);
            checks++;
            if (domain_rst_no !== exp_dom) begin
                errors++;
                $display("FAIL release_dom edge %0d got %b exp %b", e, domain_rst_no, exp_dom);
            end
            checks++;
            if (busy_o !== exp_busy) begin
                errors++;
                $display("FAIL release_busy edge %0d got %b exp %b", e, busy_o, exp_busy);
            end
        end
        checks++;
        if (rst_cause_o !== 5'b00001) begin
            errors++;
            $display("FAIL release_cause got %b exp 00001", rst_cause_o);
        end
    endtask

    task automatic test_single_req();
        logic [2:0] exp_dom;
        logic       exp_busy;
        rst_req_i[1] = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (e == 5) rst_req_i[1] = 1'b0;
            exp_dom = (e < 3) ? 3'b111 : (e < 24) ? 3'b000 : (e < 28) ? 3'b001 :
                      (e < 32) ? 3'b011 : 3'b111;
            exp_busy = (e >= 3) && (e < 32);
            checks++;
            if (domain_rst_no !== exp_dom) begin
                errors++;
                $display("FAIL single_dom edge %0d got %b exp %b", e, domain_rst_no, exp_dom);
            end
            checks++;
            if (busy_o !== exp_busy) begin
                errors++;
                $display("FAIL single_busy edge %0d got %b exp %b", e, busy_o, exp_busy);
            end
            if (e == 3) begin
                checks++;
                if (rst_cause_o !== 5'b00101) begin
                    errors++;
                    $display("FAIL single_cause got %b exp 00101", rst_cause_o);
                end
            end
        end
    endtask

    task automatic test_mid_release();
        logic [2:0] exp_dom;
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        for (int e = 1; e <= 44; e++) begin
            tick();
            if (e == 16) rst_req_i[0] = 1'b1;
            if (e == 17) rst_req_i[0] = 1'b0;
            exp_dom = (e < 16) ? 3'b000 : (e < 19) ? 3'b001 : (e < 36) ? 3'b000 :
                      (e < 40) ? 3'b001 : (e < 44) ? 3'b011 : 3'b111;
            checks++;
            if (domain_rst_no !== exp_dom) begin
                errors++;
                $display("FAIL midrel_dom edge %0d got %b exp %b", e, domain_rst_no, exp_dom);
            end
        end
        checks++;
        if (rst_cause_o !== 5'b00011) begin
            errors++;
            $display("FAIL midrel_cause got %b exp 00011", rst_cause_o);
        end
    endtask

    task automatic test_disabled();
        rst_req_en_i = 4'h0;
        rst_req_i = 4'hF;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++;
            if (domain_rst_no !== 3'b111) begin
                errors++;
                $display("FAIL dis_dom edge %0d got %b exp 111", e, domain_rst_no);
            end
            checks++;
            if (busy_o !== 1'b0) begin
                errors++;
                $display("FAIL dis_busy edge %0d got %b exp 0", e, busy_o);
            end
            checks++;
            if (rst_cause_o !== 5'b00011) begin
                errors++;
                $display("FAIL dis_cause edge %0d got %b exp 00011", e, rst_cause_o);
            end
        end
        rst_req_i = 4'h0;
        repeat (3) tick();
        rst_req_en_i = 4'hF;
    endtask

    task automatic test_cause_clr();
        int waited;
        rst_req_i[3] = 1'b1;
        tick();
        tick();
        rst_cause_clr_i = 1'b1;
        tick();
        rst_cause_clr_i = 1'b0;
        rst_req_i[3] = 1'b0;
        checks++;
        if (rst_cause_o !== 5'b10000) begin
            errors++;
            $display("FAIL clr_race_cause got %b exp 10000", rst_cause_o);
        end
        checks++;
        if (domain_rst_no !== 3'b000) begin
            errors++;
            $display("FAIL clr_race_dom got %b exp 000", domain_rst_no);
        end
        waited = 0;
        while (busy_o !== 1'b0 && waited < 60) begin
            tick();
            waited++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_idle_timeout busy got %b exp 0 after %0d edges", busy_o, waited);
        end
        rst_cause_clr_i = 1'b1;
        tick();
        rst_cause_clr_i = 1'b0;
        checks++;
        if (rst_cause_o !== 5'b00000) begin
            errors++;
            $display("FAIL clr_only_cause got %b exp 00000", rst_cause_o);
        end
        checks++;
        if (domain_rst_no !== 3'b111) begin
            errors++;
            $display("FAIL clr_only_dom got %b exp 111", domain_rst_no);
        end
    endtask

    task automatic test_async_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (18) tick();
        checks++;
        if (domain_rst_no !== 3'b001) begin
            errors++;
            $display("FAIL async_pre_dom got %b exp 001", domain_rst_no);
        end
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (domain_rst_no !== 3'b000) begin
            errors++;
            $display("FAIL async_dom got %b exp 000", domain_rst_no);
        end
        checks++;
        if (rst_cause_o !== 5'b00001) begin
            errors++;
            $display("FAIL async_cause got %b exp 00001", rst_cause_o);
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL async_busy got %b exp 1", busy_o);
        end
        tick();
        tick();
        rst_i = 1'b0;
        repeat (24) tick();
        checks++;
        if (domain_rst_no !== 3'b111) begin
            errors++;
            $display("FAIL async_recover_dom got %b exp 111", domain_rst_no);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL async_recover_busy got %b exp 0", busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_mid_release();
        test_disabled();
        test_cause_clr();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
